avmm_mem_responder: RTL and testbench
=====================================

Name: avmm_mem_responder

Overview:
- Avalon-MM slave memory responder: the SDRAM-side endpoint that the copy/DNN accelerator masters talk to.
- Serves single-word reads and writes from an on-chip word array.
- Inserts a programmable number of wait states, then returns read data through a fixed-latency readdatavalid pipeline.
- Used as a synthesizable stand-in for SDRAM in block-level simulation and FPGA bring-up; exercises master waitrequest/readdatavalid handling.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0.
- DEPTH, 256: number of 32-bit words; power of two, 2..4096.
- WAIT_STATES, 2: cycles waitrequest stays high after a request is first seen, before grant; 0..15.
- READ_LATENCY, 2: cycles from read accept to readdatavalid; 1..8.
- ERR_DATA, 32'hDEAD_BEEF: readdata returned for out-of-range reads.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- address  in  32  byte address from master
- read  in  1  read request
- write  in  1  write request
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- waitrequest  out  1  stall; registered
- readdata  out  32  read data; valid only with readdatavalid
- readdatavalid  out  1  one-cycle read-return strobe
- err  out  1  sticky error flag
- rd_count  out  16  accepted reads, wraps
- wr_count  out  16  accepted writes, wraps

Behaviour:
- Reset values, applied while rst_n=0 at posedge: waitrequest=1, readdatavalid=0, readdata=0, err=0, rd_count=0, wr_count=0, FSM=IDLE, latency pipeline cleared. Memory contents are not reset and are undefined until written.
- Accept rule: a command is accepted on a cycle where (read|write)=1 and waitrequest=0. Only the GRANT state drives waitrequest=0.
- FSM states: IDLE, COUNT, GRANT.
  - IDLE (waitrequest=1): if read|write, go to COUNT with cnt=WAIT_STATES-1; if WAIT_STATES=0, go straight to GRANT.
  - COUNT (waitrequest=1): decrement cnt; when cnt=0, go to GRANT. If read and write both drop (protocol violation), return to IDLE with no accept and no err.
  - GRANT (waitrequest=0): sample address/read/write/writedata/byteenable; always return to IDLE.
- Timing: request first high at cycle t gives accept at cycle t+1+WAIT_STATES. Maximum throughput is one command per WAIT_STATES+2 cycles.
- Address decode: idx=(address-BASE_ADDR)>>2. In range iff address>=BASE_ADDR, address<BASE_ADDR+4*DEPTH, and address[1:0]=0.
- Write accept:
  - In range: mem[idx] byte lane k <= writedata[8k+7:8k] where byteenable[k]=1; wr_count+1.
  - Out of range: no memory change, err<=1, wr_count+1.
- Read accept:
  - Push {valid, data} into a READ_LATENCY-deep shift pipeline. Data = mem[idx] as of the accept cycle (a write in the same cycle is impossible).
  - readdatavalid=1 with readdata exactly READ_LATENCY cycles after the accept edge, for exactly one cycle; rd_count+1.
  - Out-of-range read: returns ERR_DATA with readdatavalid still asserted; err<=1.
- read=1 and write=1 together at GRANT: execute as write only, no read response, err<=1.
- readdata holds its last value when readdatavalid=0.
- Read after write to the same word: a read accepted after the write's accept cycle returns the new data.
- Counters wrap 16'hFFFF to 0. err clears only on reset.
- Reset mid-operation: in-flight read responses are discarded (no readdatavalid after reset); the FSM returns to IDLE.
- Memory is inferable as a single-port RAM with byte enables: one read or one write per cycle.

Test Plan:
- WAIT_STATES=2, READ_LATENCY=2: write 32'h1234_5678 to BASE+8 with byteenable=4'hF -> waitrequest low exactly at cycle t+3; wr_count=1.
- Read BASE+8 -> readdatavalid pulses once, 2 cycles after the accept edge, with readdata=32'h1234_5678; rd_count=1.
- Write 32'hAABB_CCDD to BASE+8 with byteenable=4'b0101, then read -> 32'h12BB_56DD.
- Read BASE+4*DEPTH -> readdata=32'hDEAD_BEEF with readdatavalid; err=1; memory unchanged. A misaligned write to BASE+2 -> err stays 1, no memory change.
- Copy-master style loop: 4 words copied from BASE+0..12 to BASE+64..76, master holding read/write until waitrequest=0 -> destination words match source; rd_count=4, wr_count=4; no extra readdatavalid pulses.
- Assert rst_n=0 one cycle after a read accept with READ_LATENCY=3 -> no readdatavalid afterwards; waitrequest=1, counters=0, FSM idle. A subsequent write/read works normally.

Source files
------------

// File: rtl/avmm_mem_responder_if.sv
// Avalon-MM command/response bundle between a bus master and the memory responder.
interface avmm_mem_responder_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave memory responder: word array behind a programmable
// wait-state handshake and a fixed-latency readdatavalid pipeline.
module avmm_mem_responder #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned WAIT_STATES  = 2,
   parameter int unsigned READ_LATENCY = 2,
   parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   avmm_mem_responder_if.slave  bus,
   output logic                 err,
   output logic [15:0]          rd_count,
   output logic [15:0]          wr_count
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
   localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_GRANT} state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_wait;
   logic          r_err;
   logic [15:0]   r_rd_count;
   logic [15:0]   r_wr_count;
   logic [31:0]   r_mem [DEPTH];
   logic          r_vld [READ_LATENCY];
   logic [31:0]   r_dat [READ_LATENCY];
   logic          r_rdv;
   logic [31:0]   r_rdata;

   logic [31:0]   w_off;
   logic          w_in_range;
   logic [AW-1:0] w_idx;
   logic          w_acc;
   logic          w_wr_acc;
   logic          w_rd_acc;

   assign w_off      = bus.address - BASE_ADDR;
   assign w_in_range = (bus.address >= BASE_ADDR) && (w_off < SPAN) && (bus.address[1:0] == 2'b00);
   assign w_idx      = w_off[AW+1:2];
   // waitrequest is low only in GRANT, so GRANT plus a request is an accept
   assign w_acc      = (r_state == S_GRANT) && (bus.read || bus.write);
   assign w_wr_acc   = w_acc && bus.write;
   assign w_rd_acc   = w_acc && bus.read && !bus.write;

   // Wait-state handshake FSM; waitrequest is registered alongside the state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_wait  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.read || bus.write) begin
                  if (WAIT_STATES == 0) begin
                     r_state <= S_GRANT;
                     r_wait  <= 1'b0;
                  end else begin
                     r_state <= S_COUNT;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            S_COUNT: begin
               if (!(bus.read || bus.write)) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == '0) begin
                  r_state <= S_GRANT;
                  r_wait  <= 1'b0;
               end else begin
                  r_cnt <= 4'(r_cnt - 4'd1);
               end
            end
            S_GRANT: begin
               r_state <= S_IDLE;
               r_wait  <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_wait  <= 1'b1;
            end
         endcase
      end
   end

   // Accept counters and sticky error flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err      <= 1'b0;
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_count <= r_wr_count + 16'd1;
            if (!w_in_range || bus.read) r_err <= 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_count <= r_rd_count + 16'd1;
            if (!w_in_range) r_err <= 1'b1;
         end
      end
   end

   // Byte-enabled memory write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (w_wr_acc && w_in_range) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (bus.byteenable[k]) r_mem[w_idx][8*k +: 8] <= bus.writedata[8*k +: 8];
         end
      end
   end

   // Read data pipeline, no reset so the first stage can sit in the RAM output register
   always_ff @(posedge clk) begin
      if (w_rd_acc) r_dat[0] <= w_in_range ? r_mem[w_idx] : ERR_DATA;
      for (int unsigned k = 1; k < READ_LATENCY; k++) r_dat[k] <= r_dat[k-1];
   end

   // Read valid pipeline and returned-data register; reset drops in-flight responses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < READ_LATENCY; k++) r_vld[k] <= 1'b0;
         r_rdv   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_vld[0] <= w_rd_acc;
         for (int unsigned k = 1; k < READ_LATENCY; k++) r_vld[k] <= r_vld[k-1];
         r_rdv <= r_vld[READ_LATENCY-1];
         if (r_vld[READ_LATENCY-1]) r_rdata <= r_dat[READ_LATENCY-1];
      end
   end

   assign bus.waitrequest   = r_wait;
   assign bus.readdata      = r_rdata;
   assign bus.readdatavalid = r_rdv;
   assign err               = r_err;
   assign rd_count          = r_rd_count;
   assign wr_count          = r_wr_count;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Directed bench: two responders (read latency 2 and 3) share one master bus
// and reset; both share the handshake timing and memory image.
module tb_avmm_mem_responder;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          WS   = 2;
   localparam int          L2   = 2;
   localparam int          L3   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        err2, err3;
   logic [15:0] rdc2, wrc2, rdc3, wrc3;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_rd  = 0;
   int exp_wr  = 0;

   always #5 clk = ~clk;

   avmm_mem_responder_if bus ();
   avmm_mem_responder_if bus3 ();

   assign bus3.address    = bus.address;
   assign bus3.read       = bus.read;
   assign bus3.write      = bus.write;
   assign bus3.writedata  = bus.writedata;
   assign bus3.byteenable = bus.byteenable;

   avmm_mem_responder #(
      .BASE_ADDR(BASE), .DEPTH(256), .WAIT_STATES(WS), .READ_LATENCY(L2), .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .err(err2), .rd_count(rdc2), .wr_count(wrc2)
   );

   avmm_mem_responder #(
      .BASE_ADDR(BASE), .DEPTH(256), .WAIT_STATES(WS), .READ_LATENCY(L3), .ERR_DATA(32'hDEAD_BEEF)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3), .err(err3), .rd_count(rdc3), .wr_count(wrc3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_rd = 0;
      exp_wr = 0;
   endtask

   // Present a command and hold it until waitrequest is low; returns at the
   // negedge right after the accept edge with the command withdrawn.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, output int waits);
      bit done;
      waits = 0;
      done  = 1'b0;
      @(negedge clk);
      bus.address    = a;
      bus.read       = rd;
      bus.write      = wr;
      bus.writedata  = d;
      bus.byteenable = be;
      for (int i = 0; i < 40 && !done; i++) begin
         if (bus.waitrequest === 1'b0) begin
            done = 1'b1;
         end else begin
            waits++;
         end
         @(negedge clk);
      end
      bus.read  = 1'b0;
      bus.write = 1'b0;
      check("accept_timeout", 32'(done), 32'd1);
   endtask

   // Watch both responders for n sample points; sample j sits j edges after the accept edge.
   task automatic watch(input int n, output int p2, output int f2, output logic [31:0] d2,
                        output int p3, output int f3, output logic [31:0] d3);
      p2 = 0; f2 = -1; d2 = '0;
      p3 = 0; f3 = -1; d3 = '0;
      for (int j = 0; j < n; j++) begin
         if (bus.readdatavalid === 1'b1) begin
            if (p2 == 0) begin f2 = j; d2 = bus.readdata; end
            p2++;
         end
         if (bus3.readdatavalid === 1'b1) begin
            if (p3 == 0) begin f3 = j; d3 = bus3.readdata; end
            p3++;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int w;
      issue(1'b0, 1'b1, a, d, be, w);
      exp_wr++;
      check("wr_waits", 32'(w), 32'(WS + 1));
      check("wr_count", 32'(wrc2), 32'(exp_wr));
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] exp, output logic [31:0] got);
      int w, p2, f2, p3, f3;
      logic [31:0] d2, d3;
      issue(1'b1, 1'b0, a, '0, 4'h0, w);
      exp_rd++;
      watch(L3 + 3, p2, f2, d2, p3, f3, d3);
      check("rd_waits", 32'(w), 32'(WS + 1));
      check("rd_pulses_L2", 32'(p2), 32'd1);
      check("rd_latency_L2", 32'(f2), 32'(L2));
      check("rd_data_L2", d2, exp);
      check("rd_pulses_L3", 32'(p3), 32'd1);
      check("rd_latency_L3", 32'(f3), 32'(L3));
      check("rd_data_L3", d3, exp);
      check("rd_count", 32'(rdc2), 32'(exp_rd));
      got = d2;
   endtask

   logic [31:0] src [4];
   logic [31:0] dat;
   int          w, p2, f2, p3, f3;
   logic [31:0] d2, d3;

   initial begin
      bus.address    = '0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.writedata  = '0;
      bus.byteenable = '0;
      src[0] = 32'h1111_0000;
      src[1] = 32'h2222_0001;
      src[2] = 32'h12BB_56DD;
      src[3] = 32'h4444_0003;

      do_reset();
      check("rst_waitrequest", 32'(bus.waitrequest), 32'd1);
      check("rst_rdv", 32'(bus.readdatavalid), 32'd0);
      check("rst_readdata", bus.readdata, 32'h0);
      check("rst_err", 32'(err2), 32'd0);
      check("rst_rd_count", 32'(rdc2), 32'd0);
      check("rst_wr_count", 32'(wrc2), 32'd0);

      do_write(BASE + 32'd8, 32'h1234_5678, 4'hF);
      do_read(BASE + 32'd8, 32'h1234_5678, dat);
      check("readdata_hold", bus.readdata, 32'h1234_5678);
      do_write(BASE + 32'd8, 32'hAABB_CCDD, 4'b0101);
      do_read(BASE + 32'd8, 32'h12BB_56DD, dat);
      check("err_clean", 32'(err2), 32'd0);

      do_read(BASE + 32'h400, 32'hDEAD_BEEF, dat);
      check("err_oor_read", 32'(err2), 32'd1);
      do_read(BASE + 32'd8, 32'h12BB_56DD, dat);
      do_read(BASE - 32'd4, 32'hDEAD_BEEF, dat);
      do_write(BASE + 32'h3FC, 32'h0BAD_F00D, 4'hF);
      do_read(BASE + 32'h3FC, 32'h0BAD_F00D, dat);

      do_write(BASE + 32'd0,  src[0], 4'hF);
      do_write(BASE + 32'd4,  src[1], 4'hF);
      do_write(BASE + 32'd12, src[3], 4'hF);
      do_write(BASE + 32'd2, 32'hFFFF_FFFF, 4'hF);
      check("err_misaligned", 32'(err2), 32'd1);
      do_read(BASE + 32'd0, src[0], dat);

      // read and write together execute as a write with no read response
      issue(1'b1, 1'b1, BASE + 32'h100, 32'h5A5A_5A5A, 4'hF, w);
      exp_wr++;
      watch(L3 + 3, p2, f2, d2, p3, f3, d3);
      check("rw_no_rdv_L2", 32'(p2), 32'd0);
      check("rw_no_rdv_L3", 32'(p3), 32'd0);
      check("rw_rd_count", 32'(rdc2), 32'(exp_rd));
      check("rw_wr_count", 32'(wrc2), 32'(exp_wr));
      do_read(BASE + 32'h100, 32'h5A5A_5A5A, dat);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         do_read(BASE + 32'(4 * i), src[i], dat);
         do_write(BASE + 32'd64 + 32'(4 * i), dat, 4'hF);
      end
      check("copy_rd_count", 32'(rdc2), 32'd4);
      check("copy_wr_count", 32'(wrc2), 32'd4);
      watch(6, p2, f2, d2, p3, f3, d3);
      check("copy_idle_rdv", 32'(p2 + p3), 32'd0);
      for (int i = 0; i < 4; i++) begin
         do_read(BASE + 32'd64 + 32'(4 * i), src[i], dat);
      end

      // reset one cycle after a read accept discards the in-flight response
      issue(1'b1, 1'b0, BASE + 32'd8, '0, 4'h0, w);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_rd = 0;
      exp_wr = 0;
      watch(6, p2, f2, d2, p3, f3, d3);
      check("midrst_rdv_L2", 32'(p2), 32'd0);
      check("midrst_rdv_L3", 32'(p3), 32'd0);
      check("midrst_waitrequest", 32'(bus3.waitrequest), 32'd1);
      check("midrst_rd_count", 32'(rdc3), 32'd0);
      check("midrst_wr_count", 32'(wrc3), 32'd0);
      check("midrst_err", 32'(err3), 32'd0);
      do_write(BASE + 32'h20, 32'hCAFE_F00D, 4'hF);
      do_read(BASE + 32'h20, 32'hCAFE_F00D, dat);
      check("post_rd_count_L3", 32'(rdc3), 32'd1);
      check("post_wr_count_L3", 32'(wrc3), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
